y_muldiv_seq: RTL

Multi-cycle unsigned multiply/divide sequencer for the CPU's HI/LO path. It owns no adder of its own. It drives the shared 32-bit add/sub unit through an operand/control port and steps it once per cycle: shift-add for MUL, restoring subtract-compare for DIV. It sits beside the ALU and is started by the control unit. It reports a one-cycle done pulse with a 64-bit result.

---
 rtl/y_muldiv_seq.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/y_muldiv_seq.sv
// y_muldiv_seq: unsigned multi-cycle MUL/DIV sequencer for the HI/LO path.
// It has no adder of its own. It steps the shared 32-bit add/sub unit once
// per cycle: shift-add for MUL, restoring subtract-compare for DIV.
module y_muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] arith_a,
  output logic [WIDTH-1:0] arith_b,
  output logic             arith_ctrl,
  input  logic [WIDTH-1:0] arith_z,
  input  logic             arith_cout
);

  typedef enum logic [1:0] {
    st_idle = 2'd0,
    st_run  = 2'd1,
    st_done = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic               busy_r, done_r, dbz_r, op_r;
  logic [WIDTH-1:0]   hi_r, lo_r, opnd_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   hi_s, lo_s, mul_h_s;
  logic               mul_c_s, qbit_s;
  logic [WIDTH:0]     div_rem_s;
  logic               last_iter_s, b_zero_s;

  // Partial remainder with the next dividend bit shifted in (33 bits wide).
  assign div_rem_s   = {hi_r, lo_r[WIDTH-1]};
  assign last_iter_s = (cnt_r == CNT_W'(WIDTH - 1));
  assign b_zero_s    = (b == {WIDTH{1'b0}});

  assign busy        = busy_r;
  assign done        = done_r;
  assign hi          = hi_r;
  assign lo          = lo_r;
  assign div_by_zero = dbz_r;

  // Next-state logic: a zero divisor skips RUN and goes straight to DONE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      st_idle: begin
        if (start) begin
          if (op && b_zero_s) state_s = st_done;
          else                state_s = st_run;
        end else begin
          state_s = st_idle;
        end
      end
      st_run: begin
        if (last_iter_s) state_s = st_done;
        else             state_s = st_run;
      end
      st_done: state_s = st_idle;
      default: state_s = st_idle;
    endcase
  end

  // Operands to the shared add/sub unit; held at zero outside RUN.
  always_comb begin
    arith_a    = {WIDTH{1'b0}};
    arith_b    = {WIDTH{1'b0}};
    arith_ctrl = 1'b0;
    if (state_r == st_run) begin
      arith_b = opnd_r;
      if (op_r) begin
        arith_a    = div_rem_s[WIDTH-1:0];
        arith_ctrl = 1'b1;
      end else begin
        arith_a    = hi_r;
        arith_ctrl = 1'b0;
      end
    end else begin
      arith_a    = {WIDTH{1'b0}};
      arith_b    = {WIDTH{1'b0}};
      arith_ctrl = 1'b0;
    end
  end

  // One iteration step: MUL does a 65-bit right shift of {carry, sum, lo};
  // DIV keeps the difference when r >= divisor (carry-out means no borrow).
  always_comb begin
    mul_c_s = 1'b0;
    mul_h_s = hi_r;
    qbit_s  = 1'b0;
    hi_s    = hi_r;
    lo_s    = lo_r;
    if (op_r) begin
      qbit_s = div_rem_s[WIDTH] | arith_cout;
      if (qbit_s) hi_s = arith_z;
      else        hi_s = div_rem_s[WIDTH-1:0];
      lo_s = {lo_r[WIDTH-2:0], qbit_s};
    end else begin
      if (lo_r[0]) begin
        mul_c_s = arith_cout;
        mul_h_s = arith_z;
      end else begin
        mul_c_s = 1'b0;
        mul_h_s = hi_r;
      end
      hi_s = {mul_c_s, mul_h_s[WIDTH-1:1]};
      lo_s = {mul_h_s[0], lo_r[WIDTH-1:1]};
    end
  end

  // Control register: state plus registered busy/done decoded from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= st_idle;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == st_run) || (state_s == st_done);
      done_r  <= (state_s == st_done);
    end
  end

  // Datapath registers: load on accepted start, step during RUN, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_r   <= {WIDTH{1'b0}};
      lo_r   <= {WIDTH{1'b0}};
      opnd_r <= {WIDTH{1'b0}};
      op_r   <= 1'b0;
      dbz_r  <= 1'b0;
      cnt_r  <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        st_idle: begin
          if (start) begin
            op_r  <= op;
            cnt_r <= {CNT_W{1'b0}};
            if (op) begin
              opnd_r <= b;
              if (b_zero_s) begin
                hi_r  <= a;
                lo_r  <= {WIDTH{1'b1}};
                dbz_r <= 1'b1;
              end else begin
                hi_r  <= {WIDTH{1'b0}};
                lo_r  <= a;
                dbz_r <= 1'b0;
              end
            end else begin
              opnd_r <= a;
              hi_r   <= {WIDTH{1'b0}};
              lo_r   <= b;
              dbz_r  <= 1'b0;
            end
          end
        end
        st_run: begin
          hi_r  <= hi_s;
          lo_r  <= lo_s;
          cnt_r <= cnt_r + CNT_W'(1);
        end
        st_done: begin
          hi_r <= hi_r;
        end
        default: begin
          hi_r <= hi_r;
        end
      endcase
    end
  end

endmodule
